// File: rtl/mips_multicycle_core.sv
// Multicycle MIPS subset core: IDLE/FETCH/DECODE/EXECUTE/WRITEBACK/HALT sequencer,
// 32-entry register file, writable instruction memory and writeback trace port.
module mips_multicycle_core #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          imem_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
  input  logic [31:0]                   imem_wdata,
  input  logic [4:0]                    dbg_raddr,
  output logic [DATA_W-1:0]             dbg_rdata,
  output logic [31:0]                   pc,
  output logic                          halted,
  output logic                          wb_valid,
  output logic [4:0]                    wb_reg,
  output logic [DATA_W-1:0]             wb_data
);

  localparam int unsigned IDX_W = $clog2(IMEM_DEPTH);
  localparam int unsigned REG_N = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [31:0]       imem [IMEM_DEPTH];
  logic [DATA_W-1:0] regs_q [REG_N];

  logic [31:0]       pc_q, ir_q;
  logic [DATA_W-1:0] a_q, b_q, aluout_q, wb_data_q;
  logic [15:0]       imm_q;
  logic              halted_q, wb_valid_q;
  logic [4:0]        wb_reg_q;

  logic [5:0]        op, funct;
  logic [DATA_W-1:0] sext_imm, zext_imm, alu_res;
  logic [31:0]       br_off;
  logic [4:0]        dest;
  logic              is_alu, is_beq, is_halt;

  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign sext_imm = {{(DATA_W-16){imm_q[15]}}, imm_q};
  assign zext_imm = {{(DATA_W-16){1'b0}}, imm_q};
  assign br_off   = {{14{imm_q[15]}}, imm_q, 2'b00};

  // Instruction decode and ALU
  always_comb begin
    alu_res = '0;
    dest    = '0;
    is_alu  = 1'b0;
    is_beq  = (op == 6'd4);
    is_halt = (op == 6'd63);
    case (op)
      6'd0: begin
        dest   = ir_q[15:11];
        is_alu = 1'b1;
        case (funct)
          6'd32:   alu_res = a_q + b_q;
          6'd34:   alu_res = a_q - b_q;
          6'd36:   alu_res = a_q & b_q;
          6'd37:   alu_res = a_q | b_q;
          6'd42:   alu_res = ($signed(a_q) < $signed(b_q)) ? DATA_W'(1) : '0;
          default: is_alu = 1'b0;
        endcase
      end
      6'd8: begin
        dest    = ir_q[20:16];
        is_alu  = 1'b1;
        alu_res = a_q + sext_imm;
      end
      6'd12: begin
        dest    = ir_q[20:16];
        is_alu  = 1'b1;
        alu_res = a_q & zext_imm;
      end
      6'd13: begin
        dest    = ir_q[20:16];
        is_alu  = 1'b1;
        alu_res = a_q | zext_imm;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (run) state_d = S_FETCH;
      S_FETCH:     state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (is_halt)     state_d = S_HALT;
        else if (is_alu) state_d = S_WRITEBACK;
        else             state_d = S_FETCH;
      end
      S_WRITEBACK: state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      imm_q      <= '0;
      aluout_q   <= '0;
      halted_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_reg_q   <= '0;
      wb_data_q  <= '0;
      for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= (state_d == S_HALT);
      wb_valid_q <= 1'b0;
      case (state_q)
        S_FETCH: begin
          ir_q <= imem[pc_q[IDX_W+1:2]];
          pc_q <= pc_q + 32'd4;
        end
        S_DECODE: begin
          a_q   <= regs_q[ir_q[25:21]];
          b_q   <= regs_q[ir_q[20:16]];
          imm_q <= ir_q[15:0];
        end
        S_EXECUTE: begin
          aluout_q <= alu_res;
          if (is_beq && (a_q == b_q)) pc_q <= pc_q + br_off;
          // Trace port is loaded here so its pulse coincides with the WRITEBACK cycle
          if (is_alu && !is_halt) begin
            wb_valid_q <= 1'b1;
            wb_reg_q   <= dest;
            wb_data_q  <= alu_res;
          end
        end
        S_WRITEBACK: if (wb_reg_q != 5'd0) regs_q[wb_reg_q] <= aluout_q;
        default: ;
      endcase
    end
  end

  // Program memory is never cleared; loads are accepted only while not executing
  always_ff @(posedge clock) begin
    if (imem_we && (reset || state_q == S_IDLE || state_q == S_HALT))
      imem[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = regs_q[dbg_raddr];
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign wb_valid  = wb_valid_q;
  assign wb_reg    = wb_reg_q;
  assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Directed bench for mips_multicycle_core: default instance plus an IMEM_DEPTH=4 instance for wrap.
module tb_mips_multicycle_core;

  localparam logic [31:0] HALT_I = 32'hFC00_0000;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, run, imem_we;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata, dbg_rdata, pc, wb_data;
  logic [4:0]  dbg_raddr, wb_reg;
  logic        halted, wb_valid;

  logic        reset4, run4, imem_we4;
  logic [1:0]  imem_waddr4;
  logic [31:0] imem_wdata4, dbg_rdata4, pc4, wb_data4;
  logic [4:0]  dbg_raddr4, wb_reg4;
  logic        halted4, wb_valid4;

  mips_multicycle_core dut (
    .clock(clock), .reset(reset), .run(run), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .dbg_raddr(dbg_raddr),
    .dbg_rdata(dbg_rdata), .pc(pc), .halted(halted), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .wb_data(wb_data)
  );

  mips_multicycle_core #(.DATA_W(32), .IMEM_DEPTH(4)) dut4 (
    .clock(clock), .reset(reset4), .run(run4), .imem_we(imem_we4),
    .imem_waddr(imem_waddr4), .imem_wdata(imem_wdata4), .dbg_raddr(dbg_raddr4),
    .dbg_rdata(dbg_rdata4), .pc(pc4), .halted(halted4), .wb_valid(wb_valid4),
    .wb_reg(wb_reg4), .wb_data(wb_data4)
  );

  logic sel = 1'b0;
  wire        m_wb_valid = sel ? wb_valid4 : wb_valid;
  wire [4:0]  m_wb_reg   = sel ? wb_reg4   : wb_reg;
  wire [31:0] m_wb_data  = sel ? wb_data4  : wb_data;
  wire        m_halted   = sel ? halted4   : halted;
  wire [31:0] m_pc       = sel ? pc4       : pc;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] itype(input int op, input int rs, input int rt, input logic [15:0] imm);
    return {6'(op), 5'(rs), 5'(rt), imm};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int addr, input logic [31:0] w);
    imem_we = 1'b1; imem_waddr = 8'(addr); imem_wdata = w;
    step();
    imem_we = 1'b0;
  endtask

  task automatic load4(input int addr, input logic [31:0] w);
    imem_we4 = 1'b1; imem_waddr4 = 2'(addr); imem_wdata4 = w;
    step();
    imem_we4 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; reset4 = 1'b1;
    step();
    reset = 1'b0; reset4 = 1'b0;
  endtask

  task automatic start();
    if (sel) run4 = 1'b1; else run = 1'b1;
    step();
    run = 1'b0; run4 = 1'b0;
  endtask

  task automatic wait_wb(input string tag, input logic [4:0] er, input logic [31:0] ed, input int en);
    int n;
    n = 0;
    do begin step(); n++; end while (!m_wb_valid && n < 24);
    chk({tag, "_valid"}, 32'(m_wb_valid), 32'd1);
    chk({tag, "_reg"},   32'(m_wb_reg),   32'(er));
    chk({tag, "_data"},  m_wb_data,       ed);
    chk({tag, "_gap"},   32'(n),          32'(en));
  endtask

  task automatic wait_halt(input string tag, input logic [31:0] epc);
    int n, w;
    n = 0; w = 0;
    do begin step(); n++; if (m_wb_valid) w++; end while (!m_halted && n < 40);
    chk({tag, "_halted"}, 32'(m_halted), 32'd1);
    chk({tag, "_pc"},     m_pc,          epc);
    chk({tag, "_nowb"},   32'(w),        32'd0);
  endtask

  logic [31:0] prog2 [13];
  logic [4:0]  r2     [10];
  logic [31:0] d2     [10];

  initial begin
    reset = 1'b1; run = 1'b0; imem_we = 1'b0; imem_waddr = '0; imem_wdata = '0; dbg_raddr = 5'd5;
    reset4 = 1'b1; run4 = 1'b0; imem_we4 = 1'b0; imem_waddr4 = '0; imem_wdata4 = '0; dbg_raddr4 = '0;
    step(); step();
    reset = 1'b0; reset4 = 1'b0;
    chk("rst_pc", pc, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_reg", 32'(wb_reg), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_reg5", dbg_rdata, 32'd0);

    // Basic add program with same-cycle visibility check on the debug port
    load(0, itype(8, 0, 1, 16'd5));
    load(1, itype(8, 0, 7, 16'd3));
    load(2, rtype(7, 1, 3, 32));
    load(3, HALT_I);
    dbg_raddr = 5'd1;
    start();
    wait_wb("t1_w0", 5'd1, 32'd5, 3);
    chk("t1_dbg_same_cycle", dbg_rdata, 32'd0);
    step();
    chk("t1_dbg_next_cycle", dbg_rdata, 32'd5);
    wait_wb("t1_w1", 5'd7, 32'd3, 3);
    wait_wb("t1_w2", 5'd3, 32'd8, 4);
    wait_halt("t1", 32'd16);
    dbg_raddr = 5'd3; #1;
    chk("t1_reg3", dbg_rdata, 32'd8);

    // ALU coverage: sub, slt signed, and/or, addi negative, andi/ori zero-extension, NOPs
    do_reset();
    prog2[0]  = rtype(1, 7, 3, 34);        r2[0] = 5'd3;  d2[0] = 32'd2;
    prog2[1]  = rtype(7, 1, 4, 34);        r2[1] = 5'd4;  d2[1] = 32'hFFFF_FFFE;
    prog2[2]  = rtype(7, 1, 5, 42);        r2[2] = 5'd5;  d2[2] = 32'd1;
    prog2[3]  = rtype(1, 7, 6, 36);        r2[3] = 5'd6;  d2[3] = 32'd1;
    prog2[4]  = rtype(1, 7, 8, 37);        r2[4] = 5'd8;  d2[4] = 32'd7;
    prog2[5]  = rtype(1, 7, 9, 42);        r2[5] = 5'd9;  d2[5] = 32'd0;
    prog2[6]  = rtype(4, 1, 10, 42);       r2[6] = 5'd10; d2[6] = 32'd1;
    prog2[7]  = itype(8, 0, 11, 16'hFFFF); r2[7] = 5'd11; d2[7] = 32'hFFFF_FFFF;
    prog2[8]  = itype(12, 11, 12, 16'hF0F0); r2[8] = 5'd12; d2[8] = 32'h0000_F0F0;
    prog2[9]  = itype(13, 0, 13, 16'h8000);  r2[9] = 5'd13; d2[9] = 32'h0000_8000;
    prog2[10] = 32'h0000_0000;
    prog2[11] = 32'h0800_0003;
    prog2[12] = HALT_I;
    for (int i = 0; i < 13; i++) load(i + 2, prog2[i]);
    start();
    wait_wb("t2_addi1", 5'd1, 32'd5, 3);
    wait_wb("t2_addi7", 5'd7, 32'd3, 4);
    for (int i = 0; i < 10; i++) wait_wb($sformatf("t2_alu%0d", i), r2[i], d2[i], 4);
    wait_halt("t2", 32'd60);

    // Countdown loop exercising taken and not-taken branches
    do_reset();
    load(0, itype(8, 0, 2, 16'd3));
    load(1, itype(8, 2, 2, 16'hFFFF));
    load(2, itype(4, 2, 0, 16'd1));
    load(3, itype(4, 0, 0, 16'hFFFD));
    load(4, HALT_I);
    start();
    wait_wb("t3_w3", 5'd2, 32'd3, 3);
    wait_wb("t3_w2", 5'd2, 32'd2, 4);
    wait_wb("t3_w1", 5'd2, 32'd1, 10);
    wait_wb("t3_w0", 5'd2, 32'd0, 10);
    wait_halt("t3", 32'd20);
    dbg_raddr = 5'd2; #1;
    chk("t3_reg2", dbg_rdata, 32'd0);

    // Writeback to $0 is traced but discarded
    do_reset();
    load(0, itype(8, 0, 0, 16'd9));
    load(1, HALT_I);
    start();
    wait_wb("t4_r0", 5'd0, 32'd9, 3);
    wait_halt("t4", 32'd8);
    dbg_raddr = 5'd0; #1;
    chk("t4_reg0", dbg_rdata, 32'd0);

    // Reset mid-EXECUTE, with an imem write landing in the reset cycle
    do_reset();
    load(0, itype(8, 0, 1, 16'd5));
    load(1, itype(8, 0, 7, 16'd3));
    load(2, rtype(7, 1, 3, 32));
    load(3, 32'h0000_0000);
    load(4, HALT_I);
    start();
    wait_wb("t5_a", 5'd1, 32'd5, 3);
    wait_wb("t5_b", 5'd7, 32'd3, 4);
    step(); step(); step();
    reset = 1'b1; imem_we = 1'b1; imem_waddr = 8'd3; imem_wdata = itype(8, 0, 4, 16'd7);
    step();
    reset = 1'b0; imem_we = 1'b0;
    chk("t5_wb_valid", 32'(wb_valid), 32'd0);
    chk("t5_pc", pc, 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);
    dbg_raddr = 5'd1; #1;
    chk("t5_reg1", dbg_rdata, 32'd0);
    dbg_raddr = 5'd7; #1;
    chk("t5_reg7", dbg_rdata, 32'd0);
    dbg_raddr = 5'd3; #1;
    chk("t5_reg3", dbg_rdata, 32'd0);
    step(); step();
    chk("t5_idle_nowb", 32'(wb_valid), 32'd0);
    chk("t5_idle_pc", pc, 32'd0);
    start();
    wait_wb("t5_r0", 5'd1, 32'd5, 3);
    wait_wb("t5_r1", 5'd7, 32'd3, 4);
    wait_wb("t5_r2", 5'd3, 32'd8, 4);
    wait_wb("t5_r3", 5'd4, 32'd7, 4);
    wait_halt("t5", 32'd20);

    // Small memory: fetch index wraps, writes while running are dropped
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) load4(i, itype(8, 1, 1, 16'd1));
    start();
    wait_wb("t6_w1", 5'd1, 32'd1, 3);
    imem_we4 = 1'b1; imem_waddr4 = 2'd0; imem_wdata4 = HALT_I;
    wait_wb("t6_w2", 5'd1, 32'd2, 4);
    imem_we4 = 1'b0;
    wait_wb("t6_w3", 5'd1, 32'd3, 4);
    wait_wb("t6_w4", 5'd1, 32'd4, 4);
    chk("t6_pc_after4", pc4, 32'd16);
    wait_wb("t6_w5", 5'd1, 32'd5, 4);
    chk("t6_pc_after5", pc4, 32'd20);
    chk("t6_not_halted", 32'(halted4), 32'd0);
    sel = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
